// File: rtl/shared_op_arbiter_if.sv
// Purpose: bundles the requester-side handshake, operator-side issue/return and
//          response signals of shared_op_arbiter into one interface.
// Ports (signals):
//   req_valid/req_ready/req_a/req_b : requester handshake and packed operands
//   op_a/op_b/op_t/op_result        : operator issue and return
//   rsp_valid/rsp_data              : one-hot result strobe and result data
//   busy                            : any issued op still in flight
// Modports: master = requesters + operator (environment), slave = arbiter.
interface shared_op_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]         op_a;
    logic [WIDTH-1:0]         op_b;
    logic                     op_t;
    logic [WIDTH-1:0]         op_result;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, op_result,
        input  req_ready, op_a, op_b, op_t, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, op_result,
        output req_ready, op_a, op_b, op_t, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/shared_op_arbiter.sv
// Purpose: round-robin arbiter sharing one fixed-latency, fully pipelined two-operand
//          operator among NUM_REQ requesters; routes each result back to its issuer.
// Ports:
//   clk : clock, all state on posedge
//   rst : synchronous reset, active-high
//   bus : shared_op_arbiter_if.slave (requests, operator issue/return, responses, busy)
module shared_op_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    shared_op_arbiter_if.slave bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned DEPTH = LATENCY + 1;

    // (base + off) mod NUM_REQ, valid for any NUM_REQ (not only powers of two)
    function automatic logic [ID_W-1:0] f_idx(input logic [ID_W-1:0] base,
                                              input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        return ID_W'(sum % NUM_REQ);
    endfunction

    logic [ID_W-1:0]    r_ptr;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [DEPTH-1:0]   r_pipe_v;
    logic [ID_W-1:0]    r_pipe_id [DEPTH];

    logic               w_any;
    logic [ID_W-1:0]    w_grant_id;
    logic [NUM_REQ-1:0] w_grant;
    logic [WIDTH-1:0]   w_req_a [NUM_REQ];
    logic [WIDTH-1:0]   w_req_b [NUM_REQ];

    // Unpack per-requester operands
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_a[g] = bus.req_a[g*WIDTH +: WIDTH];
        assign w_req_b[g] = bus.req_b[g*WIDTH +: WIDTH];
    end

    // Round-robin search starting at r_ptr; nothing is granted while in reset
    always_comb begin
        w_any      = 1'b0;
        w_grant_id = '0;
        if (!rst) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                if (!w_any && bus.req_valid[f_idx(r_ptr, off)]) begin
                    w_any      = 1'b1;
                    w_grant_id = f_idx(r_ptr, off);
                end
            end
        end
    end

    assign w_grant = w_any ? (NUM_REQ'(1) << w_grant_id) : '0;

    // Pointer, operand registers and the valid half of the tracking pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_pipe_v <= '0;
        end else begin
            if (w_any) begin
                r_ptr  <= f_idx(w_grant_id, 1);
                r_op_a <= w_req_a[w_grant_id];
                r_op_b <= w_req_b[w_grant_id];
            end
            r_pipe_v <= {r_pipe_v[DEPTH-2:0], w_any};
        end
    end

    // ID half of the tracking pipe; only meaningful alongside its valid bit
    always_ff @(posedge clk) begin
        r_pipe_id[0] <= w_grant_id;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            r_pipe_id[k] <= r_pipe_id[k-1];
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    // Stage 0 of the pipe is exactly the issue cycle
    assign bus.op_t      = r_pipe_v[0];
    // Pipe tail lines up with the operator result
    assign bus.rsp_valid = r_pipe_v[DEPTH-1] ? (NUM_REQ'(1) << r_pipe_id[DEPTH-1]) : '0;
    assign bus.rsp_data  = bus.op_result;
    assign bus.busy      = |r_pipe_v;

endmodule
